// File: rtl/y86_mem_pkg.sv
// rtl/y86_mem_pkg.sv - shared types and constants for the Y86 data-memory responder
package y86_mem_pkg;

    localparam int WORD_W        = 64;
    localparam int DEFAULT_DEPTH = 1024;

    // Responder FSM: IDLE accepts, WAIT models latency, RESP holds the result until taken
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Instruction codes the initiator decodes into req_we (writes: rmmov/call/push)
    localparam logic [3:0] ICODE_RMMOV = 4'h4;
    localparam logic [3:0] ICODE_MRMOV = 4'h5;
    localparam logic [3:0] ICODE_CALL  = 4'h8;
    localparam logic [3:0] ICODE_RET   = 4'h9;
    localparam logic [3:0] ICODE_PUSH  = 4'hA;
    localparam logic [3:0] ICODE_POP   = 4'hB;

endpackage

// File: rtl/y86_dmem_array.sv
// rtl/y86_dmem_array.sv - single-port synchronous 64-bit word RAM, read-before-write
module y86_dmem_array
    import y86_mem_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [AW-1:0]     idx_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    // Access only when enabled so the read register holds its value for the whole response
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                mem[idx_i] <= wdata_i;
            end
            rdata_q <= mem[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/y86_dmem_responder.sv
// rtl/y86_dmem_responder.sv - request/response data-memory responder with programmable latency
module y86_dmem_responder
    import y86_mem_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int LATENCY = 2,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              dmem_err
);

    localparam logic [WORD_W-1:0] DEPTH_W = 64'(DEPTH);
    localparam logic [3:0]        LAT_M1  = 4'(LATENCY - 1);

    state_e            state_q;
    logic [3:0]        cnt_q;
    logic              req_ready_q;
    logic              resp_valid_q;
    logic              resp_err_q;
    logic              err_q;
    logic              rd_ok_q;
    logic              dmem_err_q;

    logic              accept_d;
    logic              addr_err_d;
    logic [WORD_W-1:0] ram_rdata;

    // Range check uses the full 64-bit address so high garbage bits cannot alias a valid word
    assign addr_err_d = (req_addr >= DEPTH_W);
    assign accept_d   = req_valid && req_ready_q;

    y86_dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .en_i    (accept_d),
        .we_i    (accept_d && req_we && !addr_err_d),
        .idx_i   (req_addr[AW-1:0]),
        .wdata_i (req_wdata),
        .rdata_o (ram_rdata)
    );

    // Responder FSM with registered handshake outputs, latency counter and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            err_q        <= 1'b0;
            rd_ok_q      <= 1'b0;
            dmem_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        req_ready_q <= 1'b0;
                        err_q       <= addr_err_d;
                        rd_ok_q     <= !req_we && !addr_err_d;
                        dmem_err_q  <= dmem_err_q | addr_err_d;
                        cnt_q       <= LAT_M1;
                        if (LATENCY == 1) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= addr_err_d;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= err_q;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        req_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Read data is the RAM's held register, masked to zero outside a good read response
    assign resp_rdata = (resp_valid_q && rd_ok_q) ? ram_rdata : '0;
    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign dmem_err   = dmem_err_q;

endmodule
